ibex_bus_bridge: RTL and testbench



---
 rtl/ibex_bus_bridge_pkg.sv | 25 ++
 rtl/ibex_bus_bridge_if.sv | 23 ++
 rtl/ibex_bus_size_dec.sv | 24 ++
 rtl/ibex_bus_bridge.sv | 103 ++++++++++
 tb/tb_ibex_bus_bridge.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_bus_bridge_pkg.sv
// Shared bus encodings and data-phase bookkeeping types for the Ibex bus bridge.
package ibex_bus_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    // What the bus owes us in the cycle after an accepted address phase.
    typedef struct packed {
        logic valid;
        src_e src;
        logic we;
    } dphase_t;

endpackage

// File: rtl/ibex_bus_bridge_if.sv
// AHB-Lite-style single-master bus carrying the bridge's address and data phases.
interface ibex_bus_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]    TRF;
    logic [2:0]    SIZE_out;
    logic [AW-1:0] DIR_out;
    logic [2:0]    BRSTsz;
    logic          WRITE;
    logic [DW-1:0] DATW;
    logic          RDY;

    modport master (
        output TRF, SIZE_out, DIR_out, BRSTsz, WRITE, DATW,
        input  RDY
    );

    modport slave (
        input  TRF, SIZE_out, DIR_out, BRSTsz, WRITE, DATW,
        output RDY
    );
endinterface

// File: rtl/ibex_bus_size_dec.sv
// Maps LSU byte enables onto a transfer size; odd patterns fall back to a word.
module ibex_bus_size_dec
    import ibex_bus_bridge_pkg::*;
(
    input  logic [3:0] be,
    output logic [2:0] size
);

    logic [3:0] solo;

    for (genvar gi = 0; gi < 4; gi++) begin : g_solo
        assign solo[gi] = (be == (4'b0001 << gi));
    end

    always_comb begin
        size = HSIZE_WORD;
        if (|solo) begin
            size = HSIZE_BYTE;
        end else if (be == 4'b0011 || be == 4'b1100) begin
            size = HSIZE_HALF;
        end
    end

endmodule

// File: rtl/ibex_bus_bridge.sv
// Merges Ibex fetch and LSU requests onto one pipelined bus master, data side first.
module ibex_bus_bridge
    import ibex_bus_bridge_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pet_inst_o,
    input  logic [AW-1:0] instr_dir_o,
    input  logic          instr_rvalid_i,
    input  logic [DW-1:0] instr_readdat_i,
    input  logic          pet_dat_o,
    input  logic          data_we_o,
    input  logic [3:0]    data_be_o,
    input  logic [AW-1:0] data_dir_o,
    input  logic [DW-1:0] data_datw_o,
    input  logic          data_rvalid_i,
    input  logic [DW-1:0] data_readdat_i,
    output logic          instr_gnt_i,
    output logic          data_gnt_i,
    output logic [DW-1:0] READDAT,
    ibex_bus_bridge_if.master bus
);

    logic          data_sel;
    logic          instr_sel;
    logic [2:0]    size_data;
    dphase_t       phase_reg;
    dphase_t       phase_next;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] readdat_reg;
    logic          rvalid_src;
    logic [DW-1:0] rdata_src;

    ibex_bus_size_dec u_size_dec (
        .be   (data_be_o),
        .size (size_data)
    );

    // Reset (active high on rst_ni) masks both requesters out of arbitration.
    assign data_sel  = pet_dat_o & ~rst_ni;
    assign instr_sel = pet_inst_o & ~pet_dat_o & ~rst_ni;

    assign data_gnt_i  = data_sel & bus.RDY;
    assign instr_gnt_i = instr_sel & bus.RDY;

    always_comb begin
        bus.TRF      = HTRANS_IDLE;
        bus.SIZE_out = HSIZE_BYTE;
        bus.DIR_out  = '0;
        bus.WRITE    = 1'b0;
        bus.BRSTsz   = HBURST_SINGLE;
        if (data_sel) begin
            bus.TRF      = HTRANS_NONSEQ;
            bus.SIZE_out = size_data;
            bus.DIR_out  = data_dir_o;
            bus.WRITE    = data_we_o;
        end else if (instr_sel) begin
            bus.TRF      = HTRANS_NONSEQ;
            bus.SIZE_out = HSIZE_WORD;
            bus.DIR_out  = instr_dir_o;
        end
    end

    always_comb begin
        phase_next       = '0;
        phase_next.valid = data_sel | instr_sel;
        phase_next.src   = data_sel ? SRC_DATA : SRC_INSTR;
        phase_next.we    = data_sel & data_we_o;
    end

    always_comb begin
        rvalid_src = instr_rvalid_i;
        rdata_src  = instr_readdat_i;
        if (phase_reg.src == SRC_DATA) begin
            rvalid_src = data_rvalid_i;
            rdata_src  = data_readdat_i;
        end
    end

    // Everything advances only on a ready edge, so a stalled data phase is held intact.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            phase_reg   <= '0;
            wdata_reg   <= '0;
            readdat_reg <= '0;
        end else if (bus.RDY) begin
            if (phase_reg.valid && !phase_reg.we && rvalid_src) begin
                readdat_reg <= rdata_src;
            end
            phase_reg <= phase_next;
            if (data_sel && data_we_o) begin
                wdata_reg <= data_datw_o;
            end
        end
    end

    assign bus.DATW = wdata_reg;
    assign READDAT  = readdat_reg;

endmodule

// File: tb/tb_ibex_bus_bridge.sv
// Table vectors, hand sequences and random traffic against a transfer-level model of the bridge.
module tb_ibex_bus_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        pi;
    logic [31:0] ia;
    logic        irv;
    logic [31:0] ird;
    logic        pd;
    logic        we;
    logic [3:0]  be;
    logic [31:0] da;
    logic [31:0] wd;
    logic        drv;
    logic [31:0] drd;
    logic        igt;
    logic        dgt;
    logic [31:0] rdat;

    ibex_bus_bridge_if #(.AW(32), .DW(32)) bus ();

    ibex_bus_bridge #(.AW(32), .DW(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst),
        .pet_inst_o      (pi),
        .instr_dir_o     (ia),
        .instr_rvalid_i  (irv),
        .instr_readdat_i (ird),
        .pet_dat_o       (pd),
        .data_we_o       (we),
        .data_be_o       (be),
        .data_dir_o      (da),
        .data_datw_o     (wd),
        .data_rvalid_i   (drv),
        .data_readdat_i  (drd),
        .instr_gnt_i     (igt),
        .data_gnt_i      (dgt),
        .READDAT         (rdat),
        .bus             (bus)
    );

    typedef struct {
        logic        rst, pi;
        logic [31:0] ia;
        logic        pd, we;
        logic [3:0]  be;
        logic [31:0] da, wd;
        logic        rdy, irv;
        logic [31:0] ird;
        logic        drv;
        logic [31:0] drd;
        logic [1:0]  etrf;
        logic [31:0] edir;
        logic [2:0]  esz;
        logic        ewr, eig, edg;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Transfer-level model: the one outstanding transfer plus the two visible registers.
    bit          m_pending;
    bit          m_pend_read;
    bit          m_pend_data;
    logic [31:0] m_datw;
    logic [31:0] m_rdat;

    function automatic vec_t mk(bit r, bit p_i, logic [31:0] a_i, bit p_d, bit w,
                                logic [3:0] b, logic [31:0] a_d, logic [31:0] d_w, bit rd,
                                logic [1:0] e_trf, logic [31:0] e_dir, logic [2:0] e_sz,
                                bit e_wr, bit e_ig, bit e_dg);
        vec_t v;
        v.rst = r;   v.pi = p_i; v.ia = a_i; v.pd = p_d; v.we = w; v.be = b;
        v.da = a_d;  v.wd = d_w; v.rdy = rd;
        v.irv = 1'b0; v.ird = '0; v.drv = 1'b0; v.drd = '0;
        v.etrf = e_trf; v.edir = e_dir; v.esz = e_sz; v.ewr = e_wr; v.eig = e_ig; v.edg = e_dg;
        return v;
    endfunction

    function automatic logic [2:0] size_of(logic [3:0] b);
        if ($countones(b) == 1)             return 3'b000;
        if (b == 4'b0011 || b == 4'b1100)   return 3'b001;
        return 3'b010;
    endfunction

    task automatic model_addr(input vec_t v, output logic [1:0] t, output logic [31:0] d,
                              output logic [2:0] s, output logic w, output logic g_i,
                              output logic g_d);
        t = 2'b00; d = '0; s = 3'b000; w = 1'b0; g_i = 1'b0; g_d = 1'b0;
        if (!v.rst && v.pd) begin
            t = 2'b10; d = v.da; s = size_of(v.be); w = v.we; g_d = v.rdy;
        end else if (!v.rst && v.pi) begin
            t = 2'b10; d = v.ia; s = 3'b010; g_i = v.rdy;
        end
    endtask

    task automatic model_edge(input vec_t v);
        if (v.rst) begin
            m_pending = 0; m_pend_read = 0; m_pend_data = 0; m_datw = '0; m_rdat = '0;
        end else if (v.rdy) begin
            if (m_pending && m_pend_read) begin
                if (m_pend_data && v.drv)       m_rdat = v.drd;
                else if (!m_pend_data && v.irv) m_rdat = v.ird;
            end
            m_pending   = v.pd || v.pi;
            m_pend_data = v.pd;
            m_pend_read = !(v.pd && v.we);
            if (v.pd && v.we) m_datw = v.wd;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; pi = v.pi; ia = v.ia; pd = v.pd; we = v.we; be = v.be;
        da = v.da; wd = v.wd; irv = v.irv; ird = v.ird; drv = v.drv; drd = v.drd;
        bus.RDY = v.rdy;
    endtask

    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        logic [1:0]  t;
        logic [31:0] d;
        logic [2:0]  s;
        logic        w, g_i, g_d;
        drive(v);
        #4;
        if (use_tbl) begin
            t = v.etrf; d = v.edir; s = v.esz; w = v.ewr; g_i = v.eig; g_d = v.edg;
        end else begin
            model_addr(v, t, d, s, w, g_i, g_d);
        end
        chk({tag, ".trf"},    32'(bus.TRF),      32'(t));
        chk({tag, ".dir"},    bus.DIR_out,       d);
        chk({tag, ".size"},   32'(bus.SIZE_out), 32'(s));
        chk({tag, ".write"},  32'(bus.WRITE),    32'(w));
        chk({tag, ".burst"},  32'(bus.BRSTsz),   32'd0);
        chk({tag, ".ignt"},   32'(igt),          32'(g_i));
        chk({tag, ".dgnt"},   32'(dgt),          32'(g_d));
        chk({tag, ".datw"},   bus.DATW,          m_datw);
        chk({tag, ".rdat"},   rdat,              m_rdat);
        $display("[TB] %s rst=%0b pi=%0b pd=%0b rdy=%0b trf=%0b dir=%08h sz=%0d wr=%0b ig=%0b dg=%0b datw=%08h rdat=%08h",
                 tag, v.rst, v.pi, v.pd, v.rdy, bus.TRF, bus.DIR_out, bus.SIZE_out, bus.WRITE,
                 igt, dgt, bus.DATW, rdat);
        @(posedge clk);
        model_edge(v);
        #1;
    endtask

    vec_t tbl [12];
    vec_t v;

    initial begin
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        m_pending = 0; m_pend_read = 0; m_pend_data = 0; m_datw = '0; m_rdat = '0;

        tbl[0]  = mk(1, 1, 32'h4,   0, 0, 4'h0, 32'h0,  32'h0,  1, 2'b00, 32'h0,   3'b000, 0, 0, 0);
        tbl[1]  = mk(0, 1, 32'h4,   1, 0, 4'h0, 32'h6,  32'h0,  1, 2'b10, 32'h6,   3'b010, 0, 0, 1);
        tbl[2]  = mk(0, 1, 32'h4,   0, 0, 4'h0, 32'h6,  32'h0,  1, 2'b10, 32'h4,   3'b010, 0, 1, 0);
        tbl[3]  = mk(0, 0, 32'h4,   0, 0, 4'h0, 32'h6,  32'h0,  1, 2'b00, 32'h0,   3'b000, 0, 0, 0);
        tbl[4]  = mk(0, 0, 32'h0,   1, 1, 4'h1, 32'h10, 32'hA5, 1, 2'b10, 32'h10,  3'b000, 1, 0, 1);
        tbl[5]  = mk(0, 0, 32'h0,   1, 0, 4'h3, 32'h40, 32'h0,  0, 2'b10, 32'h40,  3'b001, 0, 0, 0);
        tbl[6]  = mk(0, 0, 32'h0,   1, 1, 4'hC, 32'h44, 32'h11, 1, 2'b10, 32'h44,  3'b001, 1, 0, 1);
        tbl[7]  = mk(0, 0, 32'h0,   1, 0, 4'h5, 32'h48, 32'h0,  1, 2'b10, 32'h48,  3'b010, 0, 0, 1);
        tbl[8]  = mk(0, 0, 32'h0,   1, 0, 4'h8, 32'h4B, 32'h0,  1, 2'b10, 32'h4B,  3'b000, 0, 0, 1);
        tbl[9]  = mk(0, 1, 32'h8,   1, 0, 4'hF, 32'h4C, 32'h0,  1, 2'b10, 32'h4C,  3'b010, 0, 0, 1);
        tbl[10] = mk(0, 1, 32'h100, 0, 0, 4'h0, 32'h0,  32'h0,  0, 2'b10, 32'h100, 3'b010, 0, 0, 0);
        tbl[11] = mk(1, 0, 32'h0,   1, 1, 4'hF, 32'h50, 32'h77, 1, 2'b00, 32'h0,   3'b000, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i], 1, $sformatf("tbl%0d", i));
            if (i == 0) begin
                chk("rst.datw", bus.DATW, 32'h0);
                chk("rst.rdat", rdat, 32'h0);
            end
            if (i == 4) chk("write.datw", bus.DATW, 32'hA5);
        end

        // Fetch stalled by RDY low, then accepted, then its read data returns.
        v = mk(0, 1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0, 0, 2'b10, 32'h4, 3'b010, 0, 0, 0);
        step(v, 1, "stall0");
        step(v, 1, "stall1");
        v = mk(0, 1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0, 1, 2'b10, 32'h4, 3'b010, 0, 1, 0);
        step(v, 1, "fetch");
        v = mk(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 2'b00, 32'h0, 3'b000, 0, 0, 0);
        v.irv = 1; v.ird = 32'hDEADBEEF;
        step(v, 1, "fetch_dp");
        chk("fetch.rdat", rdat, 32'hDEADBEEF);

        // Reset arriving during a data-side read drops the read data.
        v = mk(0, 0, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, 1, 2'b10, 32'h20, 3'b010, 0, 0, 1);
        step(v, 1, "rd_req");
        v = mk(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 2'b00, 32'h0, 3'b000, 0, 0, 0);
        v.drv = 1; v.drd = 32'h12345678;
        step(v, 1, "rd_rst");
        chk("midrst.rdat", rdat, 32'h0);
        chk("midrst.datw", bus.DATW, 32'h0);

        for (int i = 0; i < 400; i++) begin
            v = mk(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom,
                   $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                   $urandom, $urandom, ($urandom_range(0, 3) != 0), 0, 0, 0, 0, 0, 0);
            v.irv = $urandom_range(0, 1); v.ird = $urandom;
            v.drv = $urandom_range(0, 1); v.drd = $urandom;
            step(v, 0, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
